// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer for the mdfamily instructions.
// Latches operands on start, holds busy for a fixed number of cycles, then
// commits the product ({hi,lo}) or quotient/remainder (lo/hi) to HI/LO.
// mthi/mtlo write HI/LO directly in a single edge without going busy.
//
// Optional feature macro: MD_CANCEL_EN (abort of an in-flight op via cancel).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op          EX-stage mdfamily op valid / opcode
//                      (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 nop)
//   rs_val, rt_val     operands
//   md_req_d           decode-stage instruction is mdfamily
//   cancel             abort in-flight op (ignored unless MD_CANCEL_EN)
//   busy               mult/div in progress (registered)
//   stall              combinational pipeline stall request
//   done, div0         one-cycle pulses after a commit / divide-by-zero completion
//   hi, lo             HI/LO registers
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_req_d,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             cancel_c;
  logic             start_muldiv_c;

`ifdef MD_CANCEL_EN
  assign cancel_c = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_c      = 1'b0;
`endif

  assign start_muldiv_c = start & ~op[2];

  // Result datapath, evaluated from the latched operands; used only at commit.
  logic [2*W-1:0] a_ext, b_ext, prod;
  logic [W-1:0]   b_safe;
  logic [W-1:0]   quo, rem;
  logic           is_div, div_by_zero;

  always_comb begin
    a_ext = (op_q == OP_MULT[1:0]) ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    b_ext = (op_q == OP_MULT[1:0]) ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    // Truncated product of sign-extended operands equals the signed product.
    prod  = a_ext * b_ext;
  end

  always_comb begin
    is_div      = op_q[1];
    div_by_zero = (b_q == '0);
    // Avoids X from a divide by zero; the result is never committed then.
    b_safe      = div_by_zero ? W'(1) : b_q;
    quo         = a_q / b_safe;
    rem         = a_q % b_safe;
    if (op_q == OP_DIV[1:0]) begin
      if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
        // Overflow case: quotient wraps to the most negative value.
        quo = 32'h8000_0000;
        rem = '0;
      end else begin
        quo = W'($signed(a_q) / $signed(b_safe));
        rem = W'($signed(a_q) % $signed(b_safe));
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_muldiv_c) begin
          op_d    = op[1:0];
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_d = RUN;
        end else if (start && !cancel_c) begin
          if (op == OP_MTHI) hi_d = rs_val;
          if (op == OP_MTLO) lo_d = rs_val;
        end
      end
      RUN: begin
        if (cancel_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!is_div) begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
          end else if (div_by_zero) begin
            div0_d = 1'b1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign stall = md_req_d & (busy | start_muldiv_c);
  assign done  = done_q;
  assign div0  = div0_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Unused upper opcode values (6/7) fall through as no-ops.
  logic unused_op;
  assign unused_op = (op == OP_MULTU);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl with hand-computed HI/LO results.
module tb_md_unit_ctrl;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        md_req_d;
  logic        cancel;
  logic        busy, stall, done, div0;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_req_d(md_req_d), .cancel(cancel),
    .busy(busy), .stall(stall), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue a mult/div with md_req_d held, check busy/stall each busy cycle,
  // then the committed HI/LO and the done/div0 pulses.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed0,
                        input logic [31:0] oh, input logic [31:0] ol);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; md_req_d = 1'b1;
    #1 chk({tag, "_stall_start"}, 64'(stall), 64'd1);
    @(negedge clk);
    // Scramble the operands: results must come from the captured values.
    start = 1'b0; op = 3'd6; rs_val = ~a; rt_val = b + 32'd1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_stall"}, 64'(stall), 64'd1);
      chk({tag, "_done_early"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, {hi, lo}, {oh, ol});
      @(negedge clk);
    end
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_stall_end"}, 64'(stall), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_div0"}, 64'(div0), 64'(ed0));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    md_req_d = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_div0_pulse"}, 64'(div0), 64'd0);
  endtask

  task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] v,
                       input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = v;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd6; rs_val = '0; rt_val = '0;
    md_req_d = 1'b0; cancel = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, MC,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 32'h0, 32'h0);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, DC,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu0", 3'd3, 32'd7, 32'd0, DC,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC,
           32'h0, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd3, 32'd100, 32'd7, DC,
           32'd2, 32'd14, 1'b0, 32'h0, 32'h8000_0000);
    run_op("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, DC,
           32'd1, 32'hFFFF_FFFD, 1'b0, 32'd2, 32'd14);

    mt_op("mtlo", 3'd5, 32'h0000_1234, 32'd1, 32'h0000_1234);
    mt_op("mthi", 3'd4, 32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_1234);

`ifdef MD_CANCEL_EN
    // Cancel mid-divide: returns idle, no commit, no done.
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_val = 32'd50; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    for (int i = 0; i < int'(DC) + 2; i++) begin
      chk("cancel_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("cancel_hilo", {hi, lo}, {32'h0000_ABCD, 32'h0000_1234});
    // Cancel in idle suppresses mtlo.
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_val = 32'h5555_0000; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_mtlo", 64'(lo), 64'h0000_1234);
`else
    // Cancel is ignored: the multiply still commits.
    @(negedge clk);
    start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("nocancel_busy", 64'(busy), 64'd1);
    repeat (MC - 2) @(negedge clk);
    chk("nocancel_busy_last", 64'(busy), 64'd1);
    @(negedge clk);
    chk("nocancel_done", 64'(done), 64'd1);
    chk("nocancel_hilo", {hi, lo}, {32'd0, 32'd6});
`endif

    // Asynchronous reset three cycles into a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_val = 32'd40; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("prerst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (int'(DC) + 1) @(negedge clk);
    chk("arst_nocommit", {hi, lo}, 64'd0);
    chk("arst_nodone", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
